// File: rtl/tlp_rdtag_alloc_if.sv
// Handshake bundle between the Avalon read slave / tx control / rx completion
// controller and the read-tag allocator.
interface tlp_rdtag_alloc_if;
  logic       RdReq_i;
  logic [9:0] RdByteCnt_i;
  logic       RdAck_o;
  logic       RdErr_o;
  logic       TxReq_o;
  logic [3:0] TxTag_o;
  logic [7:0] TxLenDw_o;
  logic       TxAck_i;
  logic       TagRelease_i;
  logic [4:0] OutstandingCnt_o;
  logic       TagsFull_o;
  logic       TagsEmpty_o;
  logic       ReleaseErr_o;

  // Allocator side.
  modport slave (
    input  RdReq_i,
    input  RdByteCnt_i,
    input  TxAck_i,
    input  TagRelease_i,
    output RdAck_o,
    output RdErr_o,
    output TxReq_o,
    output TxTag_o,
    output TxLenDw_o,
    output OutstandingCnt_o,
    output TagsFull_o,
    output TagsEmpty_o,
    output ReleaseErr_o
  );

  // Requester / tx / rx side.
  modport master (
    output RdReq_i,
    output RdByteCnt_i,
    output TxAck_i,
    output TagRelease_i,
    input  RdAck_o,
    input  RdErr_o,
    input  TxReq_o,
    input  TxTag_o,
    input  TxLenDw_o,
    input  OutstandingCnt_o,
    input  TagsFull_o,
    input  TagsEmpty_o,
    input  ReleaseErr_o
  );
endinterface

// File: rtl/tlp_rdtag_alloc.sv
// Read-tag allocator: hands out completion-buffer tags in ascending order and
// reclaims them in head-of-line order, stalling requests while all tags are in flight.
module tlp_rdtag_alloc #(
  parameter int unsigned TAG_NUM      = 16,
  parameter int unsigned MAX_RD_BYTES = 512
) (
  input logic              AvlClk_i,
  input logic              Rstn_i,
  tlp_rdtag_alloc_if.slave bus
);

  localparam logic [3:0] TagLast  = 4'(TAG_NUM - 1);
  localparam logic [4:0] TagCnt   = 5'(TAG_NUM);
  localparam logic [9:0] MaxBytes = 10'(MAX_RD_BYTES);

  typedef enum logic [1:0] {StIdle, StIssue, StAck} state_e;

  state_e     state_q, state_d;
  logic [3:0] alloc_ptr_q, alloc_ptr_d;
  logic [3:0] rel_ptr_q, rel_ptr_d;
  logic [4:0] cnt_q, cnt_d;
  logic [9:0] len_q, len_d;
  logic       err_q, err_d;
  logic       rel_err_q, rel_err_d;

  logic len_ok;
  logic tags_full;
  logic do_alloc;
  logic do_rel;

  function automatic logic [3:0] ptr_inc(input logic [3:0] p);
    return (p == TagLast) ? 4'd0 : p + 4'd1;
  endfunction

  assign len_ok    = (bus.RdByteCnt_i != '0) && (bus.RdByteCnt_i <= MaxBytes);
  assign tags_full = (cnt_q == TagCnt);
  assign do_alloc  = (state_q == StIssue) && bus.TxAck_i;
  // A release with nothing outstanding is dropped and only flags the error.
  assign do_rel    = bus.TagRelease_i && (cnt_q != '0);

  // State register
  always_ff @(posedge AvlClk_i or negedge Rstn_i) begin
    if (!Rstn_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.RdReq_i) begin
          if (!len_ok) begin
            state_d = StAck;
          end else if (!tags_full) begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (bus.TxAck_i) begin
          state_d = StAck;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Tag pointers, occupancy and request latch
  always_comb begin
    alloc_ptr_d = do_alloc ? ptr_inc(alloc_ptr_q) : alloc_ptr_q;
    rel_ptr_d   = do_rel ? ptr_inc(rel_ptr_q) : rel_ptr_q;

    cnt_d = cnt_q;
    if (do_alloc && !do_rel) begin
      cnt_d = cnt_q + 5'd1;
    end else if (!do_alloc && do_rel) begin
      cnt_d = cnt_q - 5'd1;
    end

    len_d = len_q;
    err_d = err_q;
    if ((state_q == StIdle) && bus.RdReq_i) begin
      err_d = !len_ok;
      if (len_ok && !tags_full) begin
        len_d = bus.RdByteCnt_i;
      end
    end

    rel_err_d = rel_err_q | (bus.TagRelease_i && (cnt_q == '0));
  end

  always_ff @(posedge AvlClk_i or negedge Rstn_i) begin
    if (!Rstn_i) begin
      alloc_ptr_q <= '0;
      rel_ptr_q   <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
      rel_err_q   <= 1'b0;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      rel_ptr_q   <= rel_ptr_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      err_q       <= err_d;
      rel_err_q   <= rel_err_d;
    end
  end

  // Outputs decoded from state and registers only
  always_comb begin
    bus.TxReq_o   = 1'b0;
    bus.TxTag_o   = '0;
    bus.TxLenDw_o = '0;
    bus.RdAck_o   = 1'b0;
    bus.RdErr_o   = 1'b0;
    unique case (state_q)
      StIssue: begin
        bus.TxReq_o   = 1'b1;
        bus.TxTag_o   = alloc_ptr_q;
        bus.TxLenDw_o = 8'((len_q + 10'd3) >> 2);
      end
      StAck: begin
        bus.RdAck_o = 1'b1;
        bus.RdErr_o = err_q;
      end
      default: ;
    endcase
  end

  assign bus.OutstandingCnt_o = cnt_q;
  assign bus.TagsFull_o       = tags_full;
  assign bus.TagsEmpty_o      = (cnt_q == '0);
  assign bus.ReleaseErr_o     = rel_err_q;

endmodule
